// File: rtl/sram_controller.sv
// 32-bit word access to a 16-bit asynchronous SRAM, split into low and high halfword phases.
// Optional macro SRAM_OFFSET_EN rebases byte addresses by the 1024-byte data memory base.
module sram_controller #(
   parameter int unsigned ACC_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   inout  wire  [15:0] SRAM_DQ,
   output logic [17:0] SRAM_ADDR,
   output logic        SRAM_WE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_CE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam logic [3:0] LastCnt = 4'(ACC_CYCLES - 1);

   typedef enum logic [1:0] {StIdle, StLow, StHigh, StDone} state_e;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        is_wr_q, is_wr_d;
   logic [15:0] word_q, word_d;
   logic [31:0] rdata_q, rdata_d;
   logic [15:0] word_idx;
   logic        drive;
   logic        unused_addr;

   // 1024 has no bits below [10], so rebasing the word index alone is exact.
`ifdef SRAM_OFFSET_EN
   assign word_idx = address[17:2] - 16'd256;
`else
   assign word_idx = address[17:2];
`endif
   assign unused_addr = ^{address[31:18], address[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         is_wr_q <= 1'b0;
         word_q  <= 16'd0;
         rdata_q <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         is_wr_q <= is_wr_d;
         word_q  <= word_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      is_wr_d = is_wr_q;
      word_d  = word_q;
      rdata_d = rdata_q;
      unique case (state_q)
         StIdle: begin
            if (wr_en || rd_en) begin
               state_d = StLow;
               cnt_d   = 4'd0;
               is_wr_d = wr_en;
               word_d  = word_idx;
            end
         end
         StLow: begin
            if (cnt_q == LastCnt) begin
               state_d = StHigh;
               cnt_d   = 4'd0;
               if (!is_wr_q) rdata_d[15:0] = SRAM_DQ;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StHigh: begin
            if (cnt_q == LastCnt) begin
               state_d = StDone;
               cnt_d   = 4'd0;
               if (!is_wr_q) rdata_d[31:16] = SRAM_DQ;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      SRAM_ADDR = 18'd0;
      if (state_q == StLow)  SRAM_ADDR = {1'b0, word_q, 1'b0};
      if (state_q == StHigh) SRAM_ADDR = {1'b0, word_q, 1'b1};
   end

   assign drive     = is_wr_q && (state_q == StLow || state_q == StHigh);
   assign SRAM_DQ   = drive ? ((state_q == StHigh) ? writeData[31:16] : writeData[15:0]) : 16'hzzzz;
   assign SRAM_WE_N = ~drive;
   assign SRAM_OE_N = 1'b0;
   assign SRAM_CE_N = 1'b0;
   assign SRAM_UB_N = 1'b0;
   assign SRAM_LB_N = 1'b0;
   assign ready     = (state_q == StDone) || (state_q == StIdle && !wr_en && !rd_en);
   assign readData  = rdata_q;

endmodule

// File: tb/tb_sram_controller.sv
// Randomized bench for sram_controller: a halfword SRAM model on the bus and a word-level
// reference memory predicting per-cycle bus activity, ready and readData.
module tb_sram_controller;

   localparam int unsigned AccCycles = 2;
   localparam int unsigned NumWords  = 16;
`ifdef SRAM_OFFSET_EN
   localparam logic [31:0] Base = 32'd1024;
`else
   localparam logic [31:0] Base = 32'd0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = 32'd0;
   logic [31:0] writeData = 32'd0;
   logic [31:0] readData;
   logic        ready;
   wire  [15:0] SRAM_DQ;
   logic [17:0] SRAM_ADDR;
   logic        SRAM_WE_N, SRAM_OE_N, SRAM_CE_N, SRAM_UB_N, SRAM_LB_N;

   logic [15:0] sram_mem [128];
   logic [31:0] ref_mem [NumWords];
   logic [31:0] rdata_exp = 32'd0;
   int          total = 0;
   int          bad = 0;

   sram_controller #(.ACC_CYCLES(AccCycles)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .address   (address),
      .writeData (writeData),
      .readData  (readData),
      .ready     (ready),
      .SRAM_DQ   (SRAM_DQ),
      .SRAM_ADDR (SRAM_ADDR),
      .SRAM_WE_N (SRAM_WE_N),
      .SRAM_OE_N (SRAM_OE_N),
      .SRAM_CE_N (SRAM_CE_N),
      .SRAM_UB_N (SRAM_UB_N),
      .SRAM_LB_N (SRAM_LB_N)
   );

   always #5 clk = ~clk;

   // Asynchronous SRAM: drives the bus whenever it is not being written.
   assign SRAM_DQ = (SRAM_WE_N && !SRAM_OE_N) ? sram_mem[SRAM_ADDR[6:0]] : 16'hzzzz;
   always @(posedge clk) if (!SRAM_WE_N) sram_mem[SRAM_ADDR[6:0]] <= SRAM_DQ;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // One complete access; the expected bus trace follows from the phase lengths.
   task automatic access(input bit do_wr, input bit do_rd, input int w, input logic [31:0] data,
                         input bit early_drop);
      bit          eff_wr;
      int          last;
      logic [17:0] a_lo, exp_addr;
      bit          active;
      eff_wr = do_wr;
      last   = 2 * AccCycles + 1;
      a_lo   = 18'(w * 2);
      @(posedge clk);
      #1;
      wr_en     = do_wr;
      rd_en     = do_rd;
      address   = Base + 32'(w * 4) + 32'($urandom_range(0, 3));
      writeData = data;
      for (int c = 0; c <= last; c++) begin
         @(negedge clk);
         active   = (c != 0) && (c != last);
         exp_addr = !active ? 18'd0 : (c <= AccCycles) ? a_lo : (a_lo | 18'd1);
         check("ready", 32'(ready), 32'(c == last));
         check("sram_addr", 32'(SRAM_ADDR), 32'(exp_addr));
         check("we_n", 32'(SRAM_WE_N), 32'(!(eff_wr && active)));
         if (eff_wr && active)
            check("dq_write", 32'(SRAM_DQ), (c <= AccCycles) ? 32'(data[15:0]) : 32'(data[31:16]));
         if (c == 1 && early_drop) begin
            wr_en = 1'b0;
            rd_en = 1'b0;
         end
         if (c == last) begin
            if (eff_wr) ref_mem[w] = data;
            else rdata_exp = ref_mem[w];
            check("read_data", readData, rdata_exp);
            check("strobes", 32'({SRAM_CE_N, SRAM_OE_N, SRAM_UB_N, SRAM_LB_N}), 32'd0);
            wr_en = 1'b0;
            rd_en = 1'b0;
         end
      end
   endtask

   task automatic reset_mid_read(input int w);
      @(posedge clk);
      #1;
      rd_en   = 1'b1;
      address = Base + 32'(w * 4);
      for (int c = 0; c <= int'(AccCycles) + 1; c++) @(negedge clk);
      rd_en = 1'b0;
      rst   = 1'b1;
      #1;
      rdata_exp = 32'd0;
      check("rst_read_data", readData, 32'd0);
      check("rst_we_n", 32'(SRAM_WE_N), 32'd1);
      check("rst_addr", 32'(SRAM_ADDR), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_read_data", readData, 32'd0);
   endtask

   initial begin
      int op;
      #12;
      check("init_ready", 32'(ready), 32'd1);
      check("init_read_data", readData, 32'd0);
      check("init_we_n", 32'(SRAM_WE_N), 32'd1);
      check("init_addr", 32'(SRAM_ADDR), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int w = 0; w < int'(NumWords); w++) access(1'b1, 1'b0, w, $urandom, 1'b0);
      access(1'b1, 1'b0, 0, 32'h12345678, 1'b0);
      access(1'b0, 1'b1, 0, 32'h0, 1'b0);
      access(1'b1, 1'b1, 1, 32'hCAFEBABE, 1'b0);
      access(1'b0, 1'b1, 1, 32'h0, 1'b1);

      for (int i = 0; i < 40; i++) begin
         op = $urandom_range(0, 2);
         access(op != 1, op != 0, $urandom_range(0, NumWords - 1), $urandom,
                1'($urandom_range(0, 1)));
      end

      reset_mid_read($urandom_range(0, NumWords - 1));
      access(1'b0, 1'b1, $urandom_range(0, NumWords - 1), 32'h0, 1'b0);
      for (int i = 0; i < 10; i++) begin
         op = $urandom_range(0, 2);
         access(op != 1, op != 0, $urandom_range(0, NumWords - 1), $urandom, 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
